bcd_adder: RTL and testbench



---
 rtl/bcd_adder.sv | 51 +++++
 tb/tb_bcd_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/bcd_adder.sv
// bcd_adder: registered multi-digit BCD adder with per-digit decimal correction.
// Out-of-range digits (10..15) still go through the same correction rule; ERR flags them.
module bcd_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  IN_VALID,
    input  logic [4*DIGITS-1:0]   IN_A,
    input  logic [4*DIGITS-1:0]   IN_B,
    input  logic                  CIN,
    output logic [4*DIGITS-1:0]   SUM,
    output logic                  COUT,
    output logic                  OUT_VALID,
    output logic                  ERR
);
    logic [DIGITS:0]     c;
    logic [4:0]          s;
    logic [4*DIGITS-1:0] sum_d;
    logic                err_d;

    always_comb begin
        c     = '0;
        c[0]  = CIN;
        s     = '0;
        sum_d = '0;
        err_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s                = {1'b0, IN_A[4*i +: 4]} + {1'b0, IN_B[4*i +: 4]} + {4'd0, c[i]};
            sum_d[4*i +: 4]  = (s > 5'd9) ? s[3:0] + 4'd6 : s[3:0];
            c[i+1]           = s > 5'd9;
            err_d            = err_d | (IN_A[4*i +: 4] > 4'd9) | (IN_B[4*i +: 4] > 4'd9);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUM       <= '0;
            COUT      <= 1'b0;
            ERR       <= 1'b0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= IN_VALID;
            if (IN_VALID) begin
                SUM  <= sum_d;
                COUT <= c[DIGITS];
                ERR  <= err_d;
            end
        end
    end
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: directed checks of the 1-digit and 2-digit BCD adder against hand-computed sums.
module tb_bcd_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sum1;
    logic       cout1, ov1, err1;
    logic [7:0] sum2;
    logic       cout2, ov2, err2;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    bcd_adder #(.DIGITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_A(a[3:0]), .IN_B(b[3:0]), .CIN(cin),
        .SUM(sum1), .COUT(cout1), .OUT_VALID(ov1), .ERR(err1)
    );

    bcd_adder #(.DIGITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_A(a), .IN_B(b), .CIN(cin),
        .SUM(sum2), .COUT(cout2), .OUT_VALID(ov2), .ERR(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_sum", {28'd0, sum1}, 32'd0);
        chk("rst_ov", {31'd0, ov1}, 32'd0);

        apply(1'b1, 8'h04, 8'h05, 1'b0);
        chk("4+5_sum", {28'd0, sum1}, 32'd9);
        chk("4+5_cout", {31'd0, cout1}, 32'd0);
        chk("4+5_ov", {31'd0, ov1}, 32'd1);
        chk("4+5_err", {31'd0, err1}, 32'd0);

        apply(1'b1, 8'h05, 8'h05, 1'b0);
        chk("5+5", {27'd0, cout1, sum1}, {27'd0, 1'b1, 4'd0});

        apply(1'b1, 8'h09, 8'h09, 1'b1);
        chk("9+9+1", {27'd0, cout1, sum1}, {27'd0, 1'b1, 4'd9});

        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                for (int k = 0; k < 2; k++) begin
                    apply(1'b1, 8'(i), 8'(j), k[0]);
                    chk("sweep", 32'(cout1) * 10 + 32'(sum1), 32'(i + j + k));
                end

        apply(1'b1, 8'h0c, 8'h03, 1'b0);
        chk("12+3", {26'd0, err1, cout1, sum1}, {26'd0, 1'b1, 1'b1, 4'd5});

        apply(1'b1, 8'h0f, 8'h0f, 1'b1);
        chk("15+15+1", {26'd0, err1, cout1, sum1}, {26'd0, 1'b1, 1'b1, 4'd5});

        apply(1'b1, 8'h03, 8'h04, 1'b0);
        chk("3+4", {26'd0, err1, cout1, sum1}, {26'd0, 1'b0, 1'b0, 4'd7});
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 8'(i * 5 + 1), 8'(9 - i), i[0]);
            chk("hold_sum", {28'd0, sum1}, 32'd7);
            chk("hold_ov", {31'd0, ov1}, 32'd0);
        end

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst1", {25'd0, ov1, err1, cout1, sum1}, 32'd0);
        chk("async_rst2", {21'd0, ov2, err2, cout2, sum2}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        apply(1'b0, 8'h09, 8'h09, 1'b1);
        chk("post_rst_idle", {25'd0, ov1, err1, cout1, sum1}, 32'd0);

        apply(1'b1, 8'h99, 8'h01, 1'b0);
        chk("99+01", {23'd0, ov2, cout2, sum2}, {23'd0, 1'b1, 1'b1, 8'h00});

        apply(1'b1, 8'h45, 8'h38, 1'b1);
        chk("45+38+1", {23'd0, err2, cout2, sum2}, {23'd0, 1'b0, 1'b0, 8'h84});

        apply(1'b1, 8'h99, 8'h99, 1'b1);
        chk("99+99+1", {23'd0, err2, cout2, sum2}, {23'd0, 1'b0, 1'b1, 8'h99});

        apply(1'b1, 8'ha0, 8'h00, 1'b0);
        chk("a0+00", {23'd0, err2, cout2, sum2}, {23'd0, 1'b1, 1'b1, 8'h00});

        apply(1'b1, 8'h27, 8'h16, 1'b0);
        chk("27+16", {23'd0, err2, cout2, sum2}, {23'd0, 1'b0, 1'b0, 8'h43});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
